// File: rtl/interface_wr.sv
// Write-side lane de-permutation: right-rotates 16 lanes by the per-beat select and
// steers each beat to the IOBUF or FSC write port with a per-frame address and last flag.
module interface_wr #(
    parameter int DW          = 64,
    parameter int LANES       = 16,
    parameter int SELW        = 4,
    parameter int AW          = 6,
    parameter int FRAME_BEATS = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CLR,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic            SEL_ITR,
    input  logic [SELW-1:0] SEL_PERMW,
    input  logic [DW-1:0]   D0,
    input  logic [DW-1:0]   D1,
    input  logic [DW-1:0]   D2,
    input  logic [DW-1:0]   D3,
    input  logic [DW-1:0]   D4,
    input  logic [DW-1:0]   D5,
    input  logic [DW-1:0]   D6,
    input  logic [DW-1:0]   D7,
    input  logic [DW-1:0]   D8,
    input  logic [DW-1:0]   D9,
    input  logic [DW-1:0]   D10,
    input  logic [DW-1:0]   D11,
    input  logic [DW-1:0]   D12,
    input  logic [DW-1:0]   D13,
    input  logic [DW-1:0]   D14,
    input  logic [DW-1:0]   D15,
    input  logic            OUT_READY,
    output logic [DW-1:0]   Q0,
    output logic [DW-1:0]   Q1,
    output logic [DW-1:0]   Q2,
    output logic [DW-1:0]   Q3,
    output logic [DW-1:0]   Q4,
    output logic [DW-1:0]   Q5,
    output logic [DW-1:0]   Q6,
    output logic [DW-1:0]   Q7,
    output logic [DW-1:0]   Q8,
    output logic [DW-1:0]   Q9,
    output logic [DW-1:0]   Q10,
    output logic [DW-1:0]   Q11,
    output logic [DW-1:0]   Q12,
    output logic [DW-1:0]   Q13,
    output logic [DW-1:0]   Q14,
    output logic [DW-1:0]   Q15,
    output logic            WE_IOBUF,
    output logic            WE_FSC,
    output logic [AW-1:0]   WADDR,
    output logic            LAST
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_BEATS - 1);

    logic [DW-1:0]   d_in    [LANES];
    logic [DW-1:0]   s1_data [LANES];
    logic [DW-1:0]   s2_data [LANES];
    logic [DW-1:0]   rot     [LANES];
    logic            v1;
    logic            v2;
    logic            itr1;
    logic            itr2;
    logic [SELW-1:0] sel1;
    logic [AW-1:0]   waddr_q;
    logic            adv1;
    logic            adv2;
    logic            in_xfer;
    logic            out_xfer;

    assign d_in[0]  = D0;
    assign d_in[1]  = D1;
    assign d_in[2]  = D2;
    assign d_in[3]  = D3;
    assign d_in[4]  = D4;
    assign d_in[5]  = D5;
    assign d_in[6]  = D6;
    assign d_in[7]  = D7;
    assign d_in[8]  = D8;
    assign d_in[9]  = D9;
    assign d_in[10] = D10;
    assign d_in[11] = D11;
    assign d_in[12] = D12;
    assign d_in[13] = D13;
    assign d_in[14] = D14;
    assign d_in[15] = D15;

    assign adv2     = !v2 || OUT_READY;
    assign adv1     = !v1 || adv2;
    assign IN_READY = adv1 && !CLR;
    assign in_xfer  = IN_VALID && IN_READY;
    assign out_xfer = v2 && OUT_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1   <= 1'b0;
            itr1 <= 1'b0;
            sel1 <= '0;
            for (int i = 0; i < LANES; i++) s1_data[i] <= '0;
        end else if (CLR) begin
            v1 <= 1'b0;
        end else if (adv1) begin
            v1 <= in_xfer;
            if (in_xfer) begin
                itr1 <= SEL_ITR;
                sel1 <= SEL_PERMW;
                for (int i = 0; i < LANES; i++) s1_data[i] <= d_in[i];
            end
        end
    end

    // Right rotation: lane i takes source lane (i - s) mod LANES; the select width wraps it.
    for (genvar g = 0; g < LANES; g++) begin : g_rot
        logic [SELW-1:0] src;
        assign src    = SELW'(g) - sel1;
        assign rot[g] = s1_data[src];
    end

    // Payload is held (not reloaded) while flushing so Q keeps its last value when idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v2   <= 1'b0;
            itr2 <= 1'b0;
            for (int i = 0; i < LANES; i++) s2_data[i] <= '0;
        end else if (CLR) begin
            v2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                itr2 <= itr1;
                for (int i = 0; i < LANES; i++) s2_data[i] <= rot[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            waddr_q <= '0;
        end else if (CLR) begin
            waddr_q <= '0;
        end else if (out_xfer) begin
            if (waddr_q == LAST_ADDR) waddr_q <= '0;
            else                      waddr_q <= waddr_q + 1'b1;
        end
    end

    assign WE_IOBUF = v2 && !itr2;
    assign WE_FSC   = v2 && itr2;
    assign WADDR    = waddr_q;
    assign LAST     = v2 && (waddr_q == LAST_ADDR);

    assign Q0  = s2_data[0];
    assign Q1  = s2_data[1];
    assign Q2  = s2_data[2];
    assign Q3  = s2_data[3];
    assign Q4  = s2_data[4];
    assign Q5  = s2_data[5];
    assign Q6  = s2_data[6];
    assign Q7  = s2_data[7];
    assign Q8  = s2_data[8];
    assign Q9  = s2_data[9];
    assign Q10 = s2_data[10];
    assign Q11 = s2_data[11];
    assign Q12 = s2_data[12];
    assign Q13 = s2_data[13];
    assign Q14 = s2_data[14];
    assign Q15 = s2_data[15];

endmodule

// File: tb/tb_interface_wr.sv
// Directed self-checking bench for interface_wr: rotation, routing, addressing,
// backpressure, flush and asynchronous reset.
module tb_interface_wr;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CLR;
    logic        IN_VALID;
    logic        IN_READY;
    logic        SEL_ITR;
    logic [3:0]  SEL_PERMW;
    logic        OUT_READY;
    logic        WE_IOBUF;
    logic        WE_FSC;
    logic [5:0]  WADDR;
    logic        LAST;
    logic [63:0] d [16];
    logic [63:0] q [16];

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    interface_wr dut (
        .CLK(CLK), .RST(RST), .CLR(CLR),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .SEL_ITR(SEL_ITR), .SEL_PERMW(SEL_PERMW),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
        .D8(d[8]), .D9(d[9]), .D10(d[10]), .D11(d[11]),
        .D12(d[12]), .D13(d[13]), .D14(d[14]), .D15(d[15]),
        .OUT_READY(OUT_READY),
        .Q0(q[0]), .Q1(q[1]), .Q2(q[2]), .Q3(q[3]),
        .Q4(q[4]), .Q5(q[5]), .Q6(q[6]), .Q7(q[7]),
        .Q8(q[8]), .Q9(q[9]), .Q10(q[10]), .Q11(q[11]),
        .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15]),
        .WE_IOBUF(WE_IOBUF), .WE_FSC(WE_FSC), .WADDR(WADDR), .LAST(LAST)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lanes(input logic [63:0] v);
        for (int i = 0; i < 16; i++) d[i] = v;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (WE_IOBUF !== 1'b0) begin n_err++; $display("FAIL reset_we_iobuf got=%b exp=0", WE_IOBUF); end
        n_cmp++; if (WE_FSC !== 1'b0) begin n_err++; $display("FAIL reset_we_fsc got=%b exp=0", WE_FSC); end
        n_cmp++; if (LAST !== 1'b0) begin n_err++; $display("FAIL reset_last got=%b exp=0", LAST); end
        n_cmp++; if (WADDR !== 6'd0) begin n_err++; $display("FAIL reset_waddr got=%0d exp=0", WADDR); end
        n_cmp++; if (q[0] !== 64'd0) begin n_err++; $display("FAIL reset_q0 got=%h exp=0", q[0]); end
        n_cmp++; if (q[15] !== 64'd0) begin n_err++; $display("FAIL reset_q15 got=%h exp=0", q[15]); end
        tick();
        RST = 1'b0;
        #1;
        n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
    endtask

    task automatic test_single_beat();
        for (int i = 0; i < 16; i++) d[i] = 64'(i);
        SEL_PERMW = 4'd3; SEL_ITR = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
        #1;
        tick();
        IN_VALID = 1'b0;
        #1;
        n_cmp++; if ((WE_IOBUF | WE_FSC) !== 1'b0) begin n_err++; $display("FAIL single_early_we got=%b exp=0", WE_IOBUF | WE_FSC); end
        tick();
        n_cmp++; if (WE_IOBUF !== 1'b1) begin n_err++; $display("FAIL single_we_iobuf got=%b exp=1", WE_IOBUF); end
        n_cmp++; if (WE_FSC !== 1'b0) begin n_err++; $display("FAIL single_we_fsc got=%b exp=0", WE_FSC); end
        n_cmp++; if (q[0] !== 64'd13) begin n_err++; $display("FAIL single_q0 got=%0d exp=13", q[0]); end
        n_cmp++; if (q[1] !== 64'd14) begin n_err++; $display("FAIL single_q1 got=%0d exp=14", q[1]); end
        n_cmp++; if (q[2] !== 64'd15) begin n_err++; $display("FAIL single_q2 got=%0d exp=15", q[2]); end
        n_cmp++; if (q[3] !== 64'd0) begin n_err++; $display("FAIL single_q3 got=%0d exp=0", q[3]); end
        n_cmp++; if (q[15] !== 64'd12) begin n_err++; $display("FAIL single_q15 got=%0d exp=12", q[15]); end
        n_cmp++; if (WADDR !== 6'd0) begin n_err++; $display("FAIL single_waddr got=%0d exp=0", WADDR); end
        n_cmp++; if (LAST !== 1'b0) begin n_err++; $display("FAIL single_last got=%b exp=0", LAST); end
        tick();
        n_cmp++; if ((WE_IOBUF | WE_FSC) !== 1'b0) begin n_err++; $display("FAIL single_after_we got=%b exp=0", WE_IOBUF | WE_FSC); end
        n_cmp++; if (WADDR !== 6'd1) begin n_err++; $display("FAIL single_after_waddr got=%0d exp=1", WADDR); end
    endtask

    task automatic test_round_trip();
        logic [63:0] orig [16];
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < 16; i++) orig[i] = {$urandom, $urandom};
            for (int i = 0; i < 16; i++) d[i] = orig[(i + s) % 16];
            SEL_PERMW = 4'(s); SEL_ITR = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
            #1;
            tick();
            IN_VALID = 1'b0;
            tick();
            n_cmp++; if (WE_FSC !== 1'b1) begin n_err++; $display("FAIL rt_we_fsc s=%0d got=%b exp=1", s, WE_FSC); end
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (q[i] !== orig[i]) begin
                    n_err++; $display("FAIL rt_lane s=%0d lane=%0d got=%h exp=%h", s, i, q[i], orig[i]);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic exp_v;
        int   k;
        CLR = 1'b1; #1; tick(); CLR = 1'b0;
        SEL_PERMW = 4'd0; OUT_READY = 1'b1;
        for (int t = 0; t < 70; t++) begin
            IN_VALID = (t < 66);
            set_lanes(64'(t));
            SEL_ITR = t[0];
            #1;
            if (t < 66) begin
                n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL stream_in_ready t=%0d got=%b exp=1", t, IN_READY); end
            end
            exp_v = (t >= 2 && t < 68);
            n_cmp++; if ((WE_IOBUF | WE_FSC) !== exp_v) begin n_err++; $display("FAIL stream_valid t=%0d got=%b exp=%b", t, WE_IOBUF | WE_FSC, exp_v); end
            if (exp_v) begin
                k = t - 2;
                n_cmp++; if (q[0] !== 64'(k)) begin n_err++; $display("FAIL stream_data t=%0d got=%0d exp=%0d", t, q[0], k); end
                n_cmp++; if (WE_FSC !== k[0]) begin n_err++; $display("FAIL stream_we_fsc t=%0d got=%b exp=%b", t, WE_FSC, k[0]); end
                n_cmp++; if (WE_IOBUF !== !k[0]) begin n_err++; $display("FAIL stream_we_iobuf t=%0d got=%b exp=%b", t, WE_IOBUF, !k[0]); end
                n_cmp++; if (WADDR !== 6'(k % 64)) begin n_err++; $display("FAIL stream_waddr t=%0d got=%0d exp=%0d", t, WADDR, k % 64); end
                n_cmp++; if (LAST !== ((k % 64) == 63)) begin n_err++; $display("FAIL stream_last t=%0d got=%b exp=%b", t, LAST, (k % 64) == 63); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        int          rcv = 0;
        logic [63:0] q0_s = '0;
        logic [5:0]  wa_s = '0;
        logic        stall;
        CLR = 1'b1; #1; tick(); CLR = 1'b0;
        SEL_PERMW = 4'd0; SEL_ITR = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            stall = (cyc >= 5 && cyc < 8);
            OUT_READY = !stall;
            IN_VALID = (sent < 10);
            set_lanes(64'(100 + sent));
            #1;
            if (stall) begin
                n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, IN_READY); end
                n_cmp++; if (WE_IOBUF !== 1'b1) begin n_err++; $display("FAIL bp_we_hold cyc=%0d got=%b exp=1", cyc, WE_IOBUF); end
                if (cyc > 5) begin
                    n_cmp++; if (q[0] !== q0_s) begin n_err++; $display("FAIL bp_q_stable cyc=%0d got=%0d exp=%0d", cyc, q[0], q0_s); end
                    n_cmp++; if (WADDR !== wa_s) begin n_err++; $display("FAIL bp_waddr_stable cyc=%0d got=%0d exp=%0d", cyc, WADDR, wa_s); end
                end
            end
            q0_s = q[0];
            wa_s = WADDR;
            if ((WE_IOBUF | WE_FSC) && OUT_READY) begin
                n_cmp++; if (q[0] !== 64'(100 + rcv)) begin n_err++; $display("FAIL bp_order got=%0d exp=%0d", q[0], 100 + rcv); end
                n_cmp++; if (WADDR !== 6'(rcv)) begin n_err++; $display("FAIL bp_waddr got=%0d exp=%0d", WADDR, rcv); end
                rcv++;
            end
            if (IN_VALID && IN_READY) sent++;
            tick();
            if (rcv == 10) break;
        end
        IN_VALID = 1'b0;
        n_cmp++; if (rcv !== 10) begin n_err++; $display("FAIL bp_count got=%0d exp=10", rcv); end
    endtask

    task automatic test_clr();
        OUT_READY = 1'b0; IN_VALID = 1'b1; SEL_ITR = 1'b0; SEL_PERMW = 4'd0;
        set_lanes(64'hA0); #1; tick();
        set_lanes(64'hA1); #1; tick();
        n_cmp++; if (WE_IOBUF !== 1'b1) begin n_err++; $display("FAIL clr_full_we got=%b exp=1", WE_IOBUF); end
        n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL clr_full_ready got=%b exp=0", IN_READY); end
        CLR = 1'b1; OUT_READY = 1'b1; set_lanes(64'hA2);
        #1;
        n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL clr_in_ready got=%b exp=0", IN_READY); end
        tick();
        CLR = 1'b0; IN_VALID = 1'b0;
        #1;
        n_cmp++; if ((WE_IOBUF | WE_FSC) !== 1'b0) begin n_err++; $display("FAIL clr_we got=%b exp=0", WE_IOBUF | WE_FSC); end
        n_cmp++; if (WADDR !== 6'd0) begin n_err++; $display("FAIL clr_waddr got=%0d exp=0", WADDR); end
        n_cmp++; if (LAST !== 1'b0) begin n_err++; $display("FAIL clr_last got=%b exp=0", LAST); end
        tick();
        n_cmp++; if ((WE_IOBUF | WE_FSC) !== 1'b0) begin n_err++; $display("FAIL clr_s1_flushed got=%b exp=0", WE_IOBUF | WE_FSC); end
        IN_VALID = 1'b1; set_lanes(64'h55);
        #1; tick();
        IN_VALID = 1'b0;
        tick();
        n_cmp++; if (WE_IOBUF !== 1'b1) begin n_err++; $display("FAIL clr_next_we got=%b exp=1", WE_IOBUF); end
        n_cmp++; if (q[0] !== 64'h55) begin n_err++; $display("FAIL clr_next_data got=%h exp=55", q[0]); end
        n_cmp++; if (WADDR !== 6'd0) begin n_err++; $display("FAIL clr_next_waddr got=%0d exp=0", WADDR); end
        tick();
    endtask

    task automatic test_async_reset();
        CLR = 1'b1; #1; tick(); CLR = 1'b0;
        OUT_READY = 1'b1; SEL_PERMW = 4'd0; SEL_ITR = 1'b1;
        for (int t = 0; t < 65; t++) begin
            IN_VALID = 1'b1;
            set_lanes(64'(t + 1));
            #1;
            tick();
        end
        n_cmp++; if (WE_FSC !== 1'b1) begin n_err++; $display("FAIL ar_pre_we got=%b exp=1", WE_FSC); end
        n_cmp++; if (LAST !== 1'b1) begin n_err++; $display("FAIL ar_pre_last got=%b exp=1", LAST); end
        #2;
        RST = 1'b1;
        #1;
        n_cmp++; if ((WE_IOBUF | WE_FSC) !== 1'b0) begin n_err++; $display("FAIL ar_we got=%b exp=0", WE_IOBUF | WE_FSC); end
        n_cmp++; if (LAST !== 1'b0) begin n_err++; $display("FAIL ar_last got=%b exp=0", LAST); end
        n_cmp++; if (WADDR !== 6'd0) begin n_err++; $display("FAIL ar_waddr got=%0d exp=0", WADDR); end
        n_cmp++; if (q[0] !== 64'd0) begin n_err++; $display("FAIL ar_q0 got=%h exp=0", q[0]); end
        #3;
        RST = 1'b0; IN_VALID = 1'b0;
        #1;
        n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL ar_in_ready got=%b exp=1", IN_READY); end
        IN_VALID = 1'b1; SEL_ITR = 1'b0; set_lanes(64'h77);
        tick();
        IN_VALID = 1'b0;
        tick();
        n_cmp++; if (WE_IOBUF !== 1'b1) begin n_err++; $display("FAIL ar_next_we got=%b exp=1", WE_IOBUF); end
        n_cmp++; if (q[0] !== 64'h77) begin n_err++; $display("FAIL ar_next_data got=%h exp=77", q[0]); end
        n_cmp++; if (WADDR !== 6'd0) begin n_err++; $display("FAIL ar_next_waddr got=%0d exp=0", WADDR); end
        tick();
    endtask

    initial begin
        RST = 1'b1; CLR = 1'b0; IN_VALID = 1'b0; SEL_ITR = 1'b0; SEL_PERMW = 4'd0; OUT_READY = 1'b1;
        set_lanes(64'd0);
        test_reset();
        test_single_beat();
        test_round_trip();
        test_stream();
        test_backpressure();
        test_clr();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
